// File: rtl/switch_egress_port.sv
// -----------------------------------------------------------------------------
// switch_egress_port
//
// Output end of the 4-port switch. Words from the crossbar are buffered in a
// small FIFO. A three-state FSM checks each FIFO head against this port's ID,
// drops misrouted or loopback packets, and transmits accepted ones off-chip
// under a valid/ready handshake. Delivered and dropped packets are counted
// with saturating counters.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid, in_data[15:0]  crossbar word {data[15:8], target[7:4], source[3:0]}
//   in_ready                 FIFO not full (the arbiter grants only while high)
//   out_ready                downstream sink accepts the current word
//   valid_out                output word valid
//   source_out, target_out, data_out   fields of the transmitted packet
//   tx_done                  one-cycle pulse after each completed transmit
//   pkt_cnt, drop_cnt        delivered / dropped packet counters (saturating)
//   ovf                      sticky: in_valid arrived while the FIFO was full
//   fifo_empty, fifo_full    FIFO status
// -----------------------------------------------------------------------------
module switch_egress_port #(
    parameter logic [3:0] PORT_ID = 4'b0001,
    parameter int         DEPTH   = 4,
    parameter int         CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [15:0]      in_data,
    output logic             in_ready,
    input  logic             out_ready,
    output logic             valid_out,
    output logic [3:0]       source_out,
    output logic [3:0]       target_out,
    output logic [7:0]       data_out,
    output logic             tx_done,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             ovf,
    output logic             fifo_empty,
    output logic             fifo_full
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        SEND  = 2'd2
    } state_t;

    // ------------------------------------------------------------------ FIFO
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [15:0]   head_reg;

    state_t state_reg;
    state_t state_next;

    logic push;
    logic pop;
    logic accept;
    logic load_out;
    logic drop;
    logic done;

    assign fifo_full  = (count_reg == FULL_CNT);
    assign fifo_empty = (count_reg == '0);
    assign in_ready   = !fifo_full;

    // Fullness is judged on the registered occupancy only, so a pop at the
    // same edge never opens a slot for the word arriving at that edge.
    assign push = in_valid && !fifo_full;
    // The head is only ever consumed in CHECK, and CHECK is only entered
    // with a non-empty FIFO, so every pop has a valid entry behind it.
    assign pop  = (state_reg == CHECK);

    // Storage array without reset so it can map to RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_data;
        end
    end

    // Registered head read. It is refreshed every IDLE cycle, so on the edge
    // that moves IDLE -> CHECK it captures the entry that CHECK examines.
    always_ff @(posedge clk) begin
        if (state_reg == IDLE) begin
            head_reg <= mem[rd_ptr_reg];
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------- FSM
    // Loopback (source equal to this port) is rejected even if the target
    // matches.
    assign accept = (head_reg[7:4] == PORT_ID) && (head_reg[3:0] != PORT_ID);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        load_out   = 1'b0;
        drop       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (accept) begin
                    load_out   = 1'b1;
                    state_next = SEND;
                end else begin
                    drop       = 1'b1;
                    state_next = IDLE;
                end
            end
            SEND: begin
                // valid_out is always 1 in SEND, so out_ready alone
                // completes the handshake.
                if (out_ready) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------- output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out  <= 1'b0;
            source_out <= '0;
            target_out <= '0;
            data_out   <= '0;
            tx_done    <= 1'b0;
            pkt_cnt    <= '0;
            drop_cnt   <= '0;
            ovf        <= 1'b0;
        end else begin
            tx_done <= done;
            if (in_valid && fifo_full) begin
                ovf <= 1'b1;
            end
            // Fields are only written on accept, so they hold the last
            // transmitted packet while idle.
            if (load_out) begin
                source_out <= head_reg[3:0];
                target_out <= head_reg[7:4];
                data_out   <= head_reg[15:8];
                valid_out  <= 1'b1;
            end else if (done) begin
                valid_out  <= 1'b0;
            end
            if (done && (pkt_cnt != '1)) begin
                pkt_cnt <= pkt_cnt + 1'b1;
            end
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_switch_egress_port.sv
// -----------------------------------------------------------------------------
// tb_switch_egress_port
//
// Directed stimulus for switch_egress_port. A transaction-level model (packet
// queue plus the packet currently being checked or sent) predicts every output
// and is compared against the DUT on each falling edge. A second instance with
// 2-bit counters shares the stimulus to exercise counter saturation. Literal
// expectations at key points pin the model itself.
// -----------------------------------------------------------------------------
module tb_switch_egress_port;

    localparam logic [3:0] PID   = 4'b0001;
    localparam int         DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, valid_out, tx_done, ovf, fifo_empty, fifo_full;
    logic [3:0]  source_out, target_out;
    logic [7:0]  data_out;
    logic [7:0]  pkt_cnt, drop_cnt;

    logic        d2_in_ready, d2_valid_out, d2_tx_done, d2_ovf, d2_empty, d2_full;
    logic [3:0]  d2_source, d2_target;
    logic [7:0]  d2_data;
    logic [1:0]  d2_pkt_cnt, d2_drop_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    switch_egress_port #(.PORT_ID(PID), .DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_ready(out_ready), .valid_out(valid_out),
        .source_out(source_out), .target_out(target_out), .data_out(data_out),
        .tx_done(tx_done), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt), .ovf(ovf),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full)
    );

    switch_egress_port #(.PORT_ID(PID), .DEPTH(DEPTH), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(d2_in_ready), .out_ready(out_ready), .valid_out(d2_valid_out),
        .source_out(d2_source), .target_out(d2_target), .data_out(d2_data),
        .tx_done(d2_tx_done), .pkt_cnt(d2_pkt_cnt), .drop_cnt(d2_drop_cnt), .ovf(d2_ovf),
        .fifo_empty(d2_empty), .fifo_full(d2_full)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------ model
    logic [15:0] q[$];
    logic [15:0] cur_pkt;
    bit          busy_check;    // a packet is being examined this cycle
    bit          busy_send;     // an accepted packet is being offered
    bit          m_valid, m_tx, m_ovf, m_started;
    logic [3:0]  m_src, m_tgt;
    logic [7:0]  m_data;
    int          m_pkt, m_drop;
    bit          m_full;

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            busy_check = 0; busy_send = 0;
            m_valid = 0; m_tx = 0; m_ovf = 0;
            m_src = 0; m_tgt = 0; m_data = 0;
            m_pkt = 0; m_drop = 0;
            m_started = 1;
        end else begin
            m_full = (q.size() == DEPTH);
            if (in_valid && m_full) m_ovf = 1;
            m_tx = 0;
            if (busy_send) begin
                if (out_ready) begin
                    m_valid = 0; m_tx = 1; m_pkt++; busy_send = 0;
                end
            end else if (busy_check) begin
                cur_pkt = q.pop_front();
                busy_check = 0;
                if (cur_pkt[7:4] == PID && cur_pkt[3:0] != PID) begin
                    m_src = cur_pkt[3:0]; m_tgt = cur_pkt[7:4]; m_data = cur_pkt[15:8];
                    m_valid = 1; busy_send = 1;
                end else begin
                    m_drop++;
                end
            end else if (q.size() > 0) begin
                busy_check = 1;
            end
            if (in_valid && !m_full) q.push_back(in_data);
        end
    end

    // ---------------------------------------------------------------- compare
    always @(negedge clk) begin
        if (m_started) begin
            chk("in_ready",   int'(in_ready),   int'(q.size() != DEPTH));
            chk("fifo_full",  int'(fifo_full),  int'(q.size() == DEPTH));
            chk("fifo_empty", int'(fifo_empty), int'(q.size() == 0));
            chk("valid_out",  int'(valid_out),  int'(m_valid));
            chk("source_out", int'(source_out), int'(m_src));
            chk("target_out", int'(target_out), int'(m_tgt));
            chk("data_out",   int'(data_out),   int'(m_data));
            chk("tx_done",    int'(tx_done),    int'(m_tx));
            chk("ovf",        int'(ovf),        int'(m_ovf));
            chk("pkt_cnt",    int'(pkt_cnt),    sat(m_pkt, 255));
            chk("drop_cnt",   int'(drop_cnt),   sat(m_drop, 255));
            chk("pkt_cnt_w2", int'(d2_pkt_cnt), sat(m_pkt, 3));
            chk("drop_cnt_w2", int'(d2_drop_cnt), sat(m_drop, 3));
        end
    end

    // --------------------------------------------------------------- stimulus
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        // Reset with in_valid held high: nothing may be written.
        rst = 1'b1; in_valid = 1'b1; in_data = 16'hA512;
        tick(2);
        rst = 1'b0; in_valid = 1'b0;
        $display("reset: valid_out=%0b in_ready=%0b fifo_empty=%0b", valid_out, in_ready, fifo_empty);
        chk("rst_valid_out", int'(valid_out), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_fifo_empty", int'(fifo_empty), 1);
        chk("rst_data_out", int'(data_out), 0);
        chk("rst_pkt_cnt", int'(pkt_cnt), 0);
        tick(3);
        chk("rst_no_write", int'(fifo_empty), 1);

        // Single accept: latency E0 write, valid after E2, tx_done after E3.
        out_ready = 1'b1;
        push_word(16'hA512);
        tick(1);
        chk("acc_no_valid_e1", int'(valid_out), 0);
        tick(1);
        $display("accept A512: valid_out=%0b data=%0h tgt=%0h src=%0h", valid_out, data_out, target_out, source_out);
        chk("acc_valid_e2", int'(valid_out), 1);
        chk("acc_data", int'(data_out), 8'hA5);
        chk("acc_target", int'(target_out), 1);
        chk("acc_source", int'(source_out), 2);
        tick(1);
        chk("acc_tx_done", int'(tx_done), 1);
        chk("acc_pkt_cnt", int'(pkt_cnt), 1);
        tick(2);
        chk("acc_hold_data", int'(data_out), 8'hA5);

        // Drops: wrong target, then loopback.
        do_reset();
        push_word(16'h3342);
        push_word(16'h3311);
        tick(8);
        $display("drops: drop_cnt=%0d fifo_empty=%0b", drop_cnt, fifo_empty);
        chk("drop_cnt2", int'(drop_cnt), 2);
        chk("drop_empty", int'(fifo_empty), 1);
        chk("drop_pkt_cnt", int'(pkt_cnt), 0);

        // Backpressure: 5 stalled cycles, then one handshake.
        do_reset();
        out_ready = 1'b0;
        push_word(16'h5C12);
        tick(1);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("bp_valid", int'(valid_out), 1);
            chk("bp_data", int'(data_out), 8'h5C);
            chk("bp_pkt_cnt", int'(pkt_cnt), 0);
        end
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        $display("backpressure: pkt_cnt=%0d tx_done=%0b", pkt_cnt, tx_done);
        chk("bp_done_pkt", int'(pkt_cnt), 1);
        chk("bp_done_valid", int'(valid_out), 0);

        // Full / overflow: six back-to-back words, five fit.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = {4'h1, 4'(i), 8'h12};
            tick(1);
        end
        in_valid = 1'b0;
        $display("full: fifo_full=%0b in_ready=%0b ovf=%0b", fifo_full, in_ready, ovf);
        chk("full_flag", int'(fifo_full), 1);
        chk("full_in_ready", int'(in_ready), 0);
        chk("full_ovf", int'(ovf), 1);
        out_ready = 1'b1;
        tick(20);
        $display("full drain: pkt_cnt=%0d last data=%0h ovf=%0b", pkt_cnt, data_out, ovf);
        chk("full_pkt_cnt", int'(pkt_cnt), 5);
        chk("full_last_data", int'(data_out), 8'h14);
        chk("full_ovf_sticky", int'(ovf), 1);

        // Saturation of the 2-bit counters.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push_word(16'h3342);
            tick(3);
        end
        $display("saturate: drop_cnt=%0d drop_cnt_w2=%0d", drop_cnt, d2_drop_cnt);
        chk("sat_drop8", int'(drop_cnt), 5);
        chk("sat_drop2", int'(d2_drop_cnt), 3);

        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
